// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit store into one (sb/sh) or two (sw, little-endian) lane-masked 16-bit write beats.
// First beat one cycle after acceptance; beats hold stable while mem_ready_i is low, and requests wait (req_ready_o low) until the store drains.
module store_narrow_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      data_i,
    input  logic [1:0]       size_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [31:0]      mem_addr_o,
    output logic [15:0]      mem_data_o,
    output logic [1:0]       mem_be_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] store_cnt_o
);

    typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_is_word;
    logic [15:0]       r_hi_data;
    logic [31:0]       r_addr;
    logic [15:0]       r_data;
    logic [1:0]        r_be;
    logic              r_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_req_acc;
    logic              w_beat_acc;
    logic              w_legal;
    logic              w_last;

    assign req_ready_o = (r_state == IDLE);
    assign mem_valid_o = (r_state != IDLE);
    assign w_req_acc   = req_valid_i & req_ready_o;
    assign w_beat_acc  = mem_valid_o & mem_ready_i;
    assign w_last      = w_beat_acc & ((r_state == BEAT_HI) | ~r_is_word);

    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign mem_be_o    = r_be;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign store_cnt_o = r_cnt;

    always_comb begin
        w_legal = 1'b0;
        unique case (size_i)
            2'b00:   w_legal = 1'b1;
            2'b01:   w_legal = ~addr_i[0];
            2'b10:   w_legal = (addr_i[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_req_acc && w_legal) w_next = BEAT_LO;
            BEAT_LO: if (mem_ready_i) w_next = r_is_word ? BEAT_HI : IDLE;
            BEAT_HI: if (mem_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_is_word <= 1'b0;
            r_hi_data <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_be      <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done <= w_last;
            r_err  <= w_req_acc & ~w_legal;
            if (w_last) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_be  <= 2'b00;
            end
            if (w_req_acc && w_legal) begin
                r_is_word <= (size_i == 2'b10);
                r_hi_data <= data_i[31:16];
                if (size_i == 2'b00) begin
                    // Byte is replicated on both lanes; the enable picks the live one.
                    r_addr <= {addr_i[31:1], 1'b0};
                    r_data <= {data_i[7:0], data_i[7:0]};
                    r_be   <= addr_i[0] ? 2'b10 : 2'b01;
                end else begin
                    r_addr <= addr_i;
                    r_data <= data_i[15:0];
                    r_be   <= 2'b11;
                end
            end else if (w_beat_acc && (r_state == BEAT_LO) && r_is_word) begin
                r_addr <= r_addr + 32'd2;
                r_data <= r_hi_data;
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed test-plan scenarios plus randomized traffic, checked against a beat-queue reference model.
module tb_store_narrow_unit;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      addr_i;
    logic [31:0]      data_i;
    logic [1:0]       size_i;
    logic             mem_valid_o;
    logic             mem_ready_i;
    logic [31:0]      mem_addr_o;
    logic [15:0]      mem_data_o;
    logic [1:0]       mem_be_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] store_cnt_o;

    store_narrow_unit #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .addr_i(addr_i), .data_i(data_i), .size_i(size_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
        .done_o(done_o), .err_o(err_o), .store_cnt_o(store_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: each accepted store expands into its list of beats.
    typedef struct packed {
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        last;
    } beat_t;

    beat_t            q[$];
    logic [CNT_W-1:0] e_cnt;
    logic             e_done;
    logic             e_err;
    bit               model_on = 0;

    always @(negedge clk_i) begin
        beat_t b;
        logic  legal;
        if (model_on) begin
            chk("mem_valid", mem_valid_o, q.size() != 0);
            chk("req_ready", req_ready_o, q.size() == 0);
            if (q.size() != 0) begin
                chk("beat_addr", mem_addr_o, q[0].a);
                chk("beat_data", mem_data_o, q[0].d);
                chk("beat_be", mem_be_o, q[0].be);
            end else begin
                chk("idle_be", mem_be_o, 0);
            end
            chk("done", done_o, e_done);
            chk("err", err_o, e_err);
            chk("store_cnt", store_cnt_o, e_cnt);
        end
        if (rst_i) begin
            q.delete();
            e_cnt    = '0;
            e_done   = 1'b0;
            e_err    = 1'b0;
            model_on = 1;
        end else if (model_on) begin
            e_done = 1'b0;
            e_err  = 1'b0;
            if (q.size() != 0) begin
                if (mem_ready_i) begin
                    b = q.pop_front();
                    if (b.last) begin
                        e_done = 1'b1;
                        e_cnt  = e_cnt + 1'b1;
                    end
                end
            end else if (req_valid_i) begin
                legal = (size_i == 2'd0) ||
                        (size_i == 2'd1 && addr_i % 2 == 0) ||
                        (size_i == 2'd2 && addr_i % 4 == 0);
                if (!legal) e_err = 1'b1;
                else if (size_i == 2'd0)
                    q.push_back('{addr_i - addr_i % 2, {data_i[7:0], data_i[7:0]},
                                  (addr_i % 2 == 1) ? 2'b10 : 2'b01, 1'b1});
                else if (size_i == 2'd1)
                    q.push_back('{addr_i, data_i[15:0], 2'b11, 1'b1});
                else begin
                    q.push_back('{addr_i, data_i[15:0], 2'b11, 1'b0});
                    q.push_back('{addr_i + 32'd2, data_i[31:16], 2'b11, 1'b1});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Returns positioned one cycle after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int budget;
        budget = 50;
        addr_i = a; data_i = d; size_i = s; req_valid_i = 1'b1;
        while (!req_ready_o && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("req_timeout", 0, 1);
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        logic [CNT_W-1:0] c0;
        logic [31:0] a;
        rst_i = 1'b1; req_valid_i = 1'b0; addr_i = '0; data_i = '0; size_i = '0; mem_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_valid", mem_valid_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_data", mem_data_o, 0);
        chk("rst_be", mem_be_o, 0);
        chk("rst_cnt", store_cnt_o, 0);
        rst_i = 1'b0;
        tick();

        // sw 0x1000 = 0xDEADBEEF, memory always ready
        mem_ready_i = 1'b1;
        issue(32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
        addr_i = 32'h5555_5555; data_i = 32'h0;
        chk("sw_lo_addr", mem_addr_o, 32'h1000);
        chk("sw_lo_data", mem_data_o, 16'hBEEF);
        chk("sw_lo_be", mem_be_o, 2'b11);
        tick();
        chk("sw_hi_valid", mem_valid_o, 1);
        chk("sw_hi_addr", mem_addr_o, 32'h1002);
        chk("sw_hi_data", mem_data_o, 16'hDEAD);
        tick();
        chk("sw_done", done_o, 1);
        chk("sw_cnt", store_cnt_o, 1);
        chk("sw_ready", req_ready_o, 1);

        // sb to odd byte lands on the upper lane
        issue(32'h0000_2003, 32'h1234_56A5, 2'b00);
        chk("sb_addr", mem_addr_o, 32'h2002);
        chk("sb_data", mem_data_o, 16'hA5A5);
        chk("sb_be", mem_be_o, 2'b10);
        tick();
        chk("sb_done", done_o, 1);
        chk("sb_cnt", store_cnt_o, 2);

        // sh under backpressure with request data changing
        mem_ready_i = 1'b0;
        issue(32'h0000_0010, 32'h0000_CAFE, 2'b01);
        data_i = 32'h0000_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", mem_valid_o, 1);
            chk("bp_addr", mem_addr_o, 32'h0010);
            chk("bp_data", mem_data_o, 16'hCAFE);
            chk("bp_be", mem_be_o, 2'b11);
            chk("bp_no_done", done_o, 0);
            tick();
        end
        mem_ready_i = 1'b1;
        chk("bp_final_data", mem_data_o, 16'hCAFE);
        tick();
        chk("bp_done", done_o, 1);
        chk("bp_cnt", store_cnt_o, 3);
        tick();
        chk("bp_done_once", done_o, 0);
        chk("bp_idle", mem_valid_o, 0);

        // rejected requests
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       issue(32'h0000_0006, 32'h1111_2222, 2'b10);
                1:       issue(32'h0000_0001, 32'h3333_4444, 2'b01);
                default: issue(32'h0000_0040, 32'h5555_6666, 2'b11);
            endcase
            chk("bad_err", err_o, 1);
            chk("bad_valid", mem_valid_o, 0);
            chk("bad_ready", req_ready_o, 1);
            chk("bad_cnt", store_cnt_o, 3);
            tick();
            chk("bad_err_pulse", err_o, 0);
            chk("bad_valid2", mem_valid_o, 0);
        end

        // reset in the middle of a word's high beat
        issue(32'h0000_3000, 32'hAAAA_BBBB, 2'b10);
        tick();
        mem_ready_i = 1'b0;
        chk("rh_hi_addr", mem_addr_o, 32'h3002);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        chk("rh_valid", mem_valid_o, 0);
        chk("rh_ready", req_ready_o, 1);
        chk("rh_cnt", store_cnt_o, 0);
        chk("rh_addr", mem_addr_o, 0);
        tick();
        chk("rh_no_done", done_o, 0);
        chk("rh_cnt2", store_cnt_o, 0);

        // 16 back-to-back sb stores wrap the 4-bit counter
        prev = 0;
        req_valid_i = 1'b1;
        size_i = 2'b00;
        for (int i = 0; i < 16; i++) begin
            int budget;
            budget = 20;
            while (!req_ready_o && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) chk("b2b_timeout", 0, 1);
            addr_i = 32'h0000_4000 + i;
            data_i = $urandom;
            tick();
            tick();
            chk("b2b_done", done_o, 1);
            c0 = CNT_W'(i + 1);
            chk("b2b_cnt", store_cnt_o, c0);
            if (i > 0) chk("b2b_spacing", cyc - prev, 2);
            prev = cyc;
        end
        req_valid_i = 1'b0;
        chk("wrap_zero", store_cnt_o, 0);
        tick();

        // randomized traffic, occasional resets
        for (int i = 0; i < 1500; i++) begin
            rst_i       = ($urandom % 200) == 0;
            req_valid_i = $urandom % 2;
            a = $urandom;
            if ($urandom % 2) a[31:8] = '0;
            if ($urandom % 8 == 0) a[31:2] = '1;
            addr_i      = a;
            data_i      = $urandom;
            size_i      = 2'($urandom % 4);
            mem_ready_i = ($urandom % 4) != 0;
            tick();
        end
        rst_i = 1'b0; req_valid_i = 1'b0; mem_ready_i = 1'b1;
        repeat (5) tick();
        chk("drain_idle", mem_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
